// File: rtl/trisc_pkg.sv
// TRISC control sequencer shared definitions: opcodes, control-line indices, states.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package trisc_pkg;

  // Encoded opcodes (low nibble of the IR opcode field)
  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_INC  = 4'd1;
  localparam logic [3:0] OP_CLR  = 4'd2;
  localparam logic [3:0] OP_JMP  = 4'd3;
  localparam logic [3:0] OP_LDA  = 4'd4;
  localparam logic [3:0] OP_STA  = 4'd5;
  localparam logic [3:0] OP_ADD  = 4'd6;
  localparam logic [3:0] OP_SUB  = 4'd7;
  localparam logic [3:0] OP_JZ   = 4'd8;
  localparam logic [3:0] OP_HALT = 4'd9;

  // Control-line bit positions within Ctrl
  localparam int C_CLR_PC   = 0;
  localparam int C_LD_PC    = 1;
  localparam int C_INC_PC   = 2;
  localparam int C_LD_MAR   = 3;
  localparam int C_MEM_RD   = 4;
  localparam int C_MEM_WR   = 5;
  localparam int C_RSVD6    = 6;
  localparam int C_LD_IR    = 7;
  localparam int C_CLR_ACC  = 8;
  localparam int C_INC_ACC  = 9;
  localparam int C_LD_MDR   = 10;
  localparam int C_ACC_MDR  = 11;
  localparam int C_ACC_ALU  = 12;
  localparam int C_RSVD13   = 13;
  localparam int C_ALU_OPND = 14;
  localparam int C_ALU_SUB  = 15;

  // 5-bit encoding leaves spare codes so a corrupted state can be recovered
  typedef enum logic [4:0] {
    S_RESET, S_FETCH0, S_FRD, S_DECODE,
    S_INC, S_CLR, S_JMP, S_JZ,
    S_OPADDR, S_OPRD, S_LDACC, S_STWR,
    S_ALU_MDR, S_ALU_LATCH, S_ALU_WB, S_HALT
  } state_t;

  // Memory-operand instruction class remembered from DECODE
  typedef enum logic [1:0] {CLS_LDA, CLS_STA, CLS_ADD, CLS_SUB} op_cls_t;

  // Reserved lines C6 and C13 are never driven, whatever the decode says
  function automatic logic [15:0] ctrl_mask_rsvd(input logic [15:0] c);
    logic [15:0] r;
    r = c;
    r[C_RSVD6]  = 1'b0;
    r[C_RSVD13] = 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/trisc_wait_ctr.sv
// Memory wait-state counter: counts cycles spent in a strobe state, flags the last one.
// Latency: done_o is a decode of the registered count (valid same cycle).
// Backpressure: none; clear has priority over enable.
module trisc_wait_ctr #(
  parameter int unsigned MEM_WAIT = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic done_o
);

  localparam logic [3:0] LAST = 4'(MEM_WAIT - 1);

  logic [3:0] cnt_q, cnt_d;

  // Next count: clear wins, otherwise step by one while enabled
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  // Count register shares the sequencer's falling-edge timing
  always_ff @(negedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == LAST);

endmodule

// File: rtl/trisc_ctrl_seq.sv
// TRISC control sequencer: encoded-opcode FSM driving datapath lines C0..C15.
// Latency: one state per SysClock falling edge; Ctrl is a combinational decode of state.
// Backpressure: none; memory strobes are held for MEM_WAIT cycles (legal 1..15).
module trisc_ctrl_seq
  import trisc_pkg::*;
#(
  parameter int unsigned MEM_WAIT        = 2,
  parameter int unsigned OPW             = 4,
  parameter bit          TRAP_ON_ILLEGAL = 1'b1
) (
  input  logic           SysClock,
  input  logic           StartStop,
  input  logic [OPW-1:0] Opcode,
  input  logic           Zero,
  output logic [15:0]    Ctrl,
  output logic           Fetch,
  output logic           Halted,
  output logic           Trap
);

  state_t      state_q;
  op_cls_t     cls_q;
  logic        trap_q;
  logic        in_wait;
  logic        wait_done;
  logic        op_illegal;
  logic [15:0] ctrl_raw;

  assign in_wait = (state_q == S_FRD) || (state_q == S_OPRD) || (state_q == S_STWR);

  // Any bit above the low nibble, or a low nibble past HALT, is not an instruction
  assign op_illegal = (|(Opcode >> 4)) || (Opcode[3:0] > OP_HALT);

  // Counter is held at zero outside strobe states and on the exiting cycle,
  // so every strobe state starts from a fresh count
  trisc_wait_ctr #(.MEM_WAIT(MEM_WAIT)) u_wait (
    .clk_i  (SysClock),
    .rst_ni (StartStop),
    .clr_i  (!in_wait || wait_done),
    .en_i   (in_wait),
    .done_o (wait_done)
  );

  // Sequencer state, instruction class and sticky trap flag
  always_ff @(negedge SysClock or negedge StartStop) begin
    if (!StartStop) begin
      state_q <= S_RESET;
      cls_q   <= CLS_LDA;
      trap_q  <= 1'b0;
    end else begin
      case (state_q)
        S_RESET:  state_q <= S_FETCH0;
        S_FETCH0: state_q <= S_FRD;
        S_FRD:    if (wait_done) state_q <= S_DECODE;
        S_DECODE: begin
          if (op_illegal) begin
            trap_q  <= 1'b1;
            state_q <= TRAP_ON_ILLEGAL ? S_HALT : S_FETCH0;
          end else begin
            case (Opcode[3:0])
              OP_NOP:  state_q <= S_FETCH0;
              OP_INC:  state_q <= S_INC;
              OP_CLR:  state_q <= S_CLR;
              OP_JMP:  state_q <= S_JMP;
              OP_LDA:  begin state_q <= S_OPADDR; cls_q <= CLS_LDA; end
              OP_STA:  begin state_q <= S_OPADDR; cls_q <= CLS_STA; end
              OP_ADD:  begin state_q <= S_OPADDR; cls_q <= CLS_ADD; end
              OP_SUB:  begin state_q <= S_OPADDR; cls_q <= CLS_SUB; end
              OP_JZ:   state_q <= S_JZ;
              OP_HALT: state_q <= S_HALT;
              default: state_q <= S_FETCH0;
            endcase
          end
        end
        S_INC, S_CLR, S_JMP, S_JZ, S_LDACC, S_ALU_WB: state_q <= S_FETCH0;
        S_OPADDR:    state_q <= (cls_q == CLS_STA) ? S_STWR : S_OPRD;
        S_OPRD:      if (wait_done) state_q <= (cls_q == CLS_LDA) ? S_LDACC : S_ALU_MDR;
        S_STWR:      if (wait_done) state_q <= S_FETCH0;
        S_ALU_MDR:   state_q <= S_ALU_LATCH;
        S_ALU_LATCH: state_q <= S_ALU_WB;
        S_HALT:      state_q <= S_HALT;
        default:     state_q <= S_RESET;
      endcase
    end
  end

  // Control-line decode; only JZ looks at a live input (Zero)
  always_comb begin
    ctrl_raw = '0;
    case (state_q)
      S_RESET:  ctrl_raw[C_CLR_PC] = 1'b1;
      S_FRD:    ctrl_raw[C_MEM_RD] = 1'b1;
      S_DECODE: begin
        ctrl_raw[C_INC_PC] = 1'b1;
        ctrl_raw[C_LD_IR]  = 1'b1;
      end
      S_INC:    ctrl_raw[C_INC_ACC] = 1'b1;
      S_CLR:    ctrl_raw[C_CLR_ACC] = 1'b1;
      S_JMP:    ctrl_raw[C_LD_PC]   = 1'b1;
      S_JZ:     ctrl_raw[C_LD_PC]   = Zero;
      S_OPADDR: ctrl_raw[C_LD_MAR]  = 1'b1;
      S_OPRD: begin
        ctrl_raw[C_LD_MAR] = 1'b1;
        ctrl_raw[C_MEM_RD] = 1'b1;
        // LDA captures read data on the last strobe cycle
        ctrl_raw[C_LD_MDR] = (cls_q == CLS_LDA) && wait_done;
      end
      S_LDACC: begin
        ctrl_raw[C_LD_MDR]  = 1'b1;
        ctrl_raw[C_ACC_MDR] = 1'b1;
      end
      S_STWR: begin
        ctrl_raw[C_LD_MAR] = 1'b1;
        ctrl_raw[C_MEM_WR] = 1'b1;
      end
      S_ALU_MDR: ctrl_raw[C_LD_MDR] = 1'b1;
      S_ALU_LATCH: begin
        ctrl_raw[C_ALU_OPND] = 1'b1;
        ctrl_raw[C_ALU_SUB]  = (cls_q == CLS_SUB);
      end
      S_ALU_WB: begin
        ctrl_raw[C_ACC_ALU] = 1'b1;
        ctrl_raw[C_ALU_SUB] = (cls_q == CLS_SUB);
      end
      default: ctrl_raw = '0;
    endcase
  end

  assign Ctrl   = ctrl_mask_rsvd(ctrl_raw);
  assign Fetch  = (state_q == S_FETCH0) || (state_q == S_FRD) || (state_q == S_DECODE);
  assign Halted = (state_q == S_HALT);
  assign Trap   = trap_q;

endmodule

// File: tb/tb_trisc_ctrl_seq.sv
// Bench for trisc_ctrl_seq: three configurations run side by side against an
// instruction-level reference model; expected per-cycle outputs are queued by the
// stimulus and popped by an independent monitor.
module tb_trisc_ctrl_seq;

  typedef struct {
    logic [15:0] ctrl;
    logic        fetch;
    logic        halted;
    logic        trap;
    int          ins;
  } cyc_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        ss0, ss1, ss2;
  logic [3:0]  op0, op1;
  logic [5:0]  op2;
  logic        z0, z1, z2;
  logic [15:0] ctrl_0, ctrl_1, ctrl_2;
  logic        fet_0, fet_1, fet_2;
  logic        hlt_0, hlt_1, hlt_2;
  logic        trp_0, trp_1, trp_2;

  int   errors = 0;
  int   checks = 0;
  cyc_t exp_q [3][$];
  bit   trap_m [3];
  bit   halt_m [3];
  int   cur_ins [3];

  // inst 0: MEM_WAIT 2, trap->halt; inst 1: MEM_WAIT 3, trap->NOP; inst 2: MEM_WAIT 1, OPW 6
  trisc_ctrl_seq #(.MEM_WAIT(2), .OPW(4), .TRAP_ON_ILLEGAL(1'b1)) dut0 (
    .SysClock(clk), .StartStop(ss0), .Opcode(op0), .Zero(z0),
    .Ctrl(ctrl_0), .Fetch(fet_0), .Halted(hlt_0), .Trap(trp_0));
  trisc_ctrl_seq #(.MEM_WAIT(3), .OPW(4), .TRAP_ON_ILLEGAL(1'b0)) dut1 (
    .SysClock(clk), .StartStop(ss1), .Opcode(op1), .Zero(z1),
    .Ctrl(ctrl_1), .Fetch(fet_1), .Halted(hlt_1), .Trap(trp_1));
  trisc_ctrl_seq #(.MEM_WAIT(1), .OPW(6), .TRAP_ON_ILLEGAL(1'b1)) dut2 (
    .SysClock(clk), .StartStop(ss2), .Opcode(op2), .Zero(z2),
    .Ctrl(ctrl_2), .Fetch(fet_2), .Halted(hlt_2), .Trap(trp_2));

  function automatic int mw(input int k);
    case (k)
      0: return 2;
      1: return 3;
      default: return 1;
    endcase
  endfunction

  function automatic bit tr(input int k);
    return (k != 1);
  endfunction

  function automatic int opmax(input int k);
    return (k == 2) ? 63 : 15;
  endfunction

  task automatic drive(input int k, input logic s, input logic [5:0] o, input logic z);
    case (k)
      0: begin ss0 = s; op0 = o[3:0]; z0 = z; end
      1: begin ss1 = s; op1 = o[3:0]; z1 = z; end
      default: begin ss2 = s; op2 = o; z2 = z; end
    endcase
  endtask

  function automatic logic [18:0] sample(input int k);
    case (k)
      0: return {ctrl_0, fet_0, hlt_0, trp_0};
      1: return {ctrl_1, fet_1, hlt_1, trp_1};
      default: return {ctrl_2, fet_2, hlt_2, trp_2};
    endcase
  endfunction

  // One SysClock cycle: drive inputs after the rising edge, queue the expected outputs.
  // Opcode/Zero are random unless this cycle is the one that must see them.
  task automatic step(input int k, input logic [15:0] c, input logic f, input logic h,
                      input logic s, input logic op_set, input logic [5:0] op,
                      input logic z_set, input logic z);
    cyc_t e;
    @(posedge clk);
    #1;
    drive(k, s, op_set ? op : 6'($urandom_range(0, opmax(k))),
          z_set ? z : 1'($urandom_range(0, 1)));
    e.ctrl = c; e.fetch = f; e.halted = h; e.trap = trap_m[k]; e.ins = cur_ins[k];
    exp_q[k].push_back(e);
  endtask

  task automatic st(input int k, input logic [15:0] c);
    step(k, c, 1'b0, 1'b0, 1'b1, 1'b0, 6'd0, 1'b0, 1'b0);
  endtask

  task automatic reset_seq(input int k);
    cur_ins[k] = -1;
    trap_m[k]  = 1'b0;
    halt_m[k]  = 1'b0;
    step(k, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0);
    step(k, 16'h0001, 1'b0, 1'b0, 1'b1, 1'b0, 6'd0, 1'b0, 1'b0);
  endtask

  task automatic hold_halt(input int k, input int n);
    repeat (n) step(k, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 6'd0, 1'b0, 1'b0);
  endtask

  task automatic fetch_decode(input int k, input logic [5:0] op);
    cur_ins[k] = int'(op);
    step(k, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 6'd0, 1'b0, 1'b0);
    repeat (mw(k)) step(k, 16'h0010, 1'b1, 1'b0, 1'b1, 1'b0, 6'd0, 1'b0, 1'b0);
    step(k, 16'h0084, 1'b1, 1'b0, 1'b1, 1'b1, op, 1'b0, 1'b0);
  endtask

  // Reference model: the per-cycle Ctrl sequence of one whole instruction
  task automatic issue(input int k, input logic [5:0] op, input logic z);
    fetch_decode(k, op);
    if (op >= 6'd10) begin
      trap_m[k] = 1'b1;
      if (tr(k)) halt_m[k] = 1'b1;
    end else begin
      case (op)
        6'd1: st(k, 16'h0200);
        6'd2: st(k, 16'h0100);
        6'd3: st(k, 16'h0002);
        6'd4: begin
          st(k, 16'h0008);
          repeat (mw(k) - 1) st(k, 16'h0018);
          st(k, 16'h0418);
          st(k, 16'h0C00);
        end
        6'd5: begin
          st(k, 16'h0008);
          repeat (mw(k)) st(k, 16'h0028);
        end
        6'd6, 6'd7: begin
          st(k, 16'h0008);
          repeat (mw(k)) st(k, 16'h0018);
          st(k, 16'h0400);
          st(k, (op == 6'd7) ? 16'hC000 : 16'h4000);
          st(k, (op == 6'd7) ? 16'h9000 : 16'h1000);
        end
        6'd8: step(k, z ? 16'h0002 : 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 6'd0, 1'b1, z);
        6'd9: halt_m[k] = 1'b1;
        default: ;
      endcase
    end
  endtask

  task automatic run_op(input int k, input logic [5:0] op, input logic z);
    issue(k, op, z);
    if (halt_m[k]) begin
      hold_halt(k, 3 + int'($urandom_range(0, 4)));
      reset_seq(k);
    end
  endtask

  // STA cut short by reset during the second write cycle
  task automatic sta_abort(input int k);
    logic [18:0] g;
    fetch_decode(k, 6'd5);
    st(k, 16'h0008);
    st(k, 16'h0028);
    cur_ins[k] = -1;
    trap_m[k]  = 1'b0;
    halt_m[k]  = 1'b0;
    step(k, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0);
    #1;
    g = sample(k);
    checks++;
    if (g[18:3] !== 16'h0001 || g[8] !== 1'b0 || g[2] !== 1'b0 || g[1] !== 1'b0) begin
      errors++;
      $display("FAIL inst%0d t=%0t aborted write wait: ctrl/fetch/halted got %h/%b/%b expected 0001/0/0",
               k, $time, g[18:3], g[2], g[1]);
    end
    step(k, 16'h0001, 1'b0, 1'b0, 1'b1, 1'b0, 6'd0, 1'b0, 1'b0);
  endtask

  task automatic run(input int k);
    logic [5:0] op;
    reset_seq(k);
    run_op(k, 6'd0, 1'b0);
    run_op(k, 6'd0, 1'b0);
    for (int i = 1; i <= 8; i++) run_op(k, 6'(i), 1'b1);
    run_op(k, 6'd8, 1'b0);
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 5) == 0) op = 6'($urandom_range(0, opmax(k)));
      else op = 6'($urandom_range(0, 8));
      run_op(k, op, 1'($urandom_range(0, 1)));
    end
    reset_seq(k);
    issue(k, 6'd12, 1'b0);
    if (tr(k)) begin
      hold_halt(k, 20);
      reset_seq(k);
    end else begin
      run_op(k, 6'd4, 1'b0);
      run_op(k, 6'd7, 1'b0);
      run_op(k, 6'd5, 1'b0);
    end
    if (k == 2) run_op(k, 6'h14, 1'b0);
    if (mw(k) >= 2) sta_abort(k);
    run_op(k, 6'd5, 1'b0);
    run_op(k, 6'd9, 1'b0);
    run_op(k, 6'd0, 1'b0);
    run_op(k, 6'd6, 1'b0);
  endtask

  // Monitor: compare each instance's outputs against the queued expectation
  initial begin
    forever begin
      @(posedge clk);
      #3;
      for (int k = 0; k < 3; k++) begin
        if (exp_q[k].size() > 0) begin
          cyc_t        e;
          logic [18:0] got;
          e   = exp_q[k].pop_front();
          got = sample(k);
          checks++;
          if (got !== {e.ctrl, e.fetch, e.halted, e.trap}) begin
            errors++;
            $display("FAIL inst%0d ins=%0d t=%0t ctrl/fetch/halted/trap got %h/%b/%b/%b expected %h/%b/%b/%b",
                     k, e.ins, $time, got[18:3], got[2], got[1], got[0],
                     e.ctrl, e.fetch, e.halted, e.trap);
          end
        end
      end
    end
  end

  initial begin
    ss0 = 1'b0; ss1 = 1'b0; ss2 = 1'b0;
    op0 = 4'd0; op1 = 4'd0; op2 = 6'd0;
    z0 = 1'b0; z1 = 1'b0; z2 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      trap_m[k] = 1'b0; halt_m[k] = 1'b0; cur_ins[k] = -1;
    end
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (sample(k) !== {16'h0001, 1'b0, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL inst%0d t=%0t reset state got %h expected %h",
                 k, $time, sample(k), {16'h0001, 1'b0, 1'b0, 1'b0});
      end
    end
    fork
      run(0);
      run(1);
      run(2);
    join
    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
